// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB walk,
// shared memory port arbitration, trap on illegal/SYSTEM encodings.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [4:0]  rd,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t      state_q, state_d;
    state_t      retire_nxt;
    logic        illegal_q;
    logic [31:0] retired_q;
    logic        legal_enc, bad_enc, is_sys, is_store;

    // funct3 does not influence sequencing; the ALU decodes it itself
    logic unused_func3;
    assign unused_func3 = ^func3;

    always_comb begin
        legal_enc = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM: legal_enc = 1'b1;
            OP_OP: legal_enc = (func7 == 7'h00) || (func7 == 7'h20);
            default: legal_enc = 1'b0;
        endcase
    end

    assign is_sys   = (opcode == OP_SYSTEM);
    assign bad_enc  = !legal_enc && !is_sys;
    assign is_store = (opcode == OP_STORE);

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_we     = 1'b0;
        wb_sel     = 2'd0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        alu_op     = 2'd0;
        halted     = 1'b0;
        // run is only consulted when an instruction retires
        retire_nxt = run ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = (bad_enc || is_sys) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_LUI:   begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
                    OP_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                    OP_IMM:   begin alu_b_sel = 1'b1; alu_op = 2'd1; end
                    OP_OP:    alu_op = 2'd1;
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op  = 2'd2;
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? 2'd1 : 2'd0;
                        state_d = retire_nxt;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = retire_nxt;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                reg_we  = (rd != 5'd0);
                wb_sel  = (opcode == OP_LOAD) ? 2'd1 :
                          (opcode == OP_JAL || opcode == OP_JALR) ? 2'd2 : 2'd0;
                pc_src  = (opcode == OP_JAL) ? 2'd1 :
                          (opcode == OP_JALR) ? 2'd2 : 2'd0;
                state_d = retire_nxt;
            end
            S_TRAP: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && bad_enc) illegal_q <= 1'b1;
            if (pc_we) retired_q <= retired_q + 32'd1;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected traces built from the
// instruction class, compared cycle by cycle with randomized waits and run.
module tb_multicycle_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, br_taken = 1'b0, mem_ready = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_req, mem_we, mem_sel, ir_we, pc_we, reg_we, alu_b_sel, illegal, halted;
    logic [1:0]  pc_src, wb_sel, alu_a_sel, alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .opcode(ir[6:0]), .func3(ir[14:12]), .func7(ir[31:25]), .rd(ir[11:7]),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .state(state), .illegal(illegal), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, sel, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       regwe;
        logic [1:0] wbsel, a;
        logic       b;
        logic [1:0] op;
        logic       ill, hlt;
    } obs_t;

    typedef struct {
        obs_t o;
        logic rdy;
        logic run;
    } ent_t;

    typedef enum {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_IMM, C_OP, C_SYS, C_BAD} cls_t;

    ent_t        tr[$];
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_ret = 32'd0;
    logic        exp_ill = 1'b0;
    logic        cont = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t obs();
        obs_t o;
        o = '{state, mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, reg_we,
              wb_sel, alu_a_sel, alu_b_sel, alu_op, illegal, halted};
        return o;
    endfunction

    function automatic cls_t classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b0010011: return C_IMM;
            7'b0110011: return (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) ? C_OP : C_BAD;
            7'b1110011: return C_SYS;
            default:    return C_BAD;
        endcase
    endfunction

    function automatic ent_t mk(input logic [2:0] st);
        ent_t e;
        e.o     = '0;
        e.o.st  = st;
        e.o.hlt = (st == 3'd6);
        e.o.ill = exp_ill;
        e.rdy   = 1'($urandom % 2);
        e.run   = 1'($urandom % 2);
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from its class alone
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input logic tk, input logic ra, input logic fi, input int idle_n);
        ent_t e;
        cls_t c = classify(ins);
        tr.delete();
        if (fi) begin
            for (int i = 0; i < idle_n; i++) begin e = mk(3'd0); e.run = 1'b0; tr.push_back(e); end
            e = mk(3'd0); e.run = 1'b1; tr.push_back(e);
        end
        for (int i = 0; i <= fw; i++) begin
            e = mk(3'd1); e.o.req = 1'b1; e.rdy = (i == fw); e.o.irwe = e.rdy; tr.push_back(e);
        end
        e = mk(3'd2); tr.push_back(e);
        if (c == C_SYS || c == C_BAD) begin
            if (c == C_BAD) exp_ill = 1'b1;
            for (int i = 0; i < 100; i++) begin e = mk(3'd6); tr.push_back(e); end
            return;
        end
        e = mk(3'd3);
        case (c)
            C_BR: begin
                e.o.op = 2'd2; e.o.pcwe = 1'b1; e.o.pcsrc = {1'b0, tk}; e.run = ra;
                tr.push_back(e);
                return;
            end
            C_LUI:      begin e.o.a = 2'd2; e.o.b = 1'b1; end
            C_AUIPC:    begin e.o.a = 2'd1; e.o.b = 1'b1; end
            C_IMM:      begin e.o.b = 1'b1; e.o.op = 2'd1; end
            C_OP:       e.o.op = 2'd1;
            C_LD, C_ST: e.o.b = 1'b1;
            default: ;
        endcase
        tr.push_back(e);
        if (c == C_LD || c == C_ST) begin
            for (int i = 0; i <= mw; i++) begin
                e = mk(3'd4); e.o.req = 1'b1; e.o.sel = 1'b1; e.o.we = (c == C_ST);
                e.rdy = (i == mw);
                if (c == C_ST && i == mw) begin e.o.pcwe = 1'b1; e.run = ra; end
                tr.push_back(e);
            end
            if (c == C_ST) return;
        end
        e = mk(3'd5);
        e.o.pcwe  = 1'b1;
        e.o.regwe = (ins[11:7] != 5'd0);
        e.o.wbsel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
        e.o.pcsrc = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
        e.run = ra;
        tr.push_back(e);
    endtask

    // Drives the trace; abort_at >= 0 asserts reset at that entry instead
    task automatic exec_trace(input logic [31:0] ins, input logic tk, input int abort_at);
        logic pend = 1'b0;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            if (pend) begin ir = ins; pend = 1'b0; end
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
                chk("rst_mid_state", 64'(state), 64'd0);
                chk("rst_mid_retired", 64'(retired), 64'd0);
                chk("rst_mid_outs", 64'(obs()), 64'd0);
                return;
            end
            mem_ready = tr[i].rdy;
            run       = tr[i].run;
            br_taken  = tk;
            #1;
            chk($sformatf("cyc%0d_st%0d", i, tr[i].o.st), 64'(obs()), 64'(tr[i].o));
            pend = tr[i].o.irwe;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic tk, input logic ra);
        cls_t c = classify(ins);
        build(ins, fw, mw, tk, ra, !cont, int'($urandom % 3));
        exec_trace(ins, tk, -1);
        if (c != C_SYS && c != C_BAD) exp_ret = exp_ret + 32'd1;
        chk($sformatf("retired_%h", ins), 64'(retired), 64'(exp_ret));
        cont = ra;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0;
        #1;
        chk("rst_outs", 64'(obs()), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0; exp_ill = 1'b0; cont = 1'b0;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        logic [31:0] ins = $urandom;
        ins[6:0] = ops[$urandom % 9];
        if (ins[6:0] == 7'b0110011) ins[31:25] = ($urandom % 2 == 1) ? 7'h20 : 7'h00;
        if ($urandom % 5 == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    task automatic rand_batch(input int n);
        for (int k = 0; k < n; k++)
            do_instr(rand_ins(), int'($urandom % 3), int'($urandom % 4),
                     1'($urandom % 2), ($urandom % 4) != 0);
    endtask

    initial begin
        logic [31:0] bad;
        int          ab;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 64'(obs()), 64'd0);
        chk("reset_retired", 64'(retired), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_outs", 64'(obs()), 64'd0);

        do_instr(32'h00500093, 0, 0, 1'b0, 1'b1);   // addi x1,x0,5
        do_instr(32'h0000A103, 0, 3, 1'b0, 1'b1);   // lw, 3 wait states
        do_instr(32'h00000463, 0, 0, 1'b1, 1'b1);   // beq taken
        do_instr(32'h00000463, 2, 0, 1'b0, 1'b1);   // beq not taken
        rand_batch(60);

        // Counter wrap: park in IDLE, preload, retire one more
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        chk("preload", 64'(retired), 64'(exp_ret));
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("park_state", 64'(state), 64'd0);
            chk("park_mem_req", 64'(mem_req), 64'd0);
        end

        // Reset in the middle of a stalled store
        build(32'h00112023, 0, 6, 1'b0, 1'b1, !cont, 0);
        ab = 0;
        for (int i = 0; i < tr.size(); i++)
            if (tr[i].o.st == 3'd4 && ab == 0) ab = i + 2;
        exec_trace(32'h00112023, 1'b0, ab);
        do_reset();
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b1);

        do_instr(32'h02000033, 1, 0, 1'b0, 1'b1);   // OP with func7=0x01
        chk("trap_illegal", 64'(illegal), 64'd1);
        do_reset();
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b1);
        do_instr(32'h00000073, 0, 0, 1'b0, 1'b1);   // ecall
        chk("ecall_illegal", 64'(illegal), 64'd0);
        do_reset();

        for (int k = 0; k < 3; k++) begin
            bad = $urandom;
            while (classify(bad) != C_BAD) bad = $urandom;
            do_instr(bad, 0, 0, 1'b0, 1'b1);
            do_reset();
        end
        rand_batch(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
